// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA pixel/line counters with registered hsync, vsync, video_on and frame_start.
// Latency: all outputs are registered and describe the position held in pix_x/pix_y in the same cycle.
// Flow: pix_en gates every advance, so outputs hold when it is low. frame_cnt exists only with VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // Window bounds are 12 bits wide so an end bound of 2048 still compares correctly.
  localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
  localparam logic [11:0] HS_BEG = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
  localparam logic [11:0] VS_BEG = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d, y_q, y_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        video_q, video_d, fs_q, fs_d;
  logic        hs_act, vs_act;

  // Next position, then decode of that position so the registered flags line up with the counters.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = 11'd0;
        y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    hs_act  = ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END);
    vs_act  = ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END);
    hsync_d = hs_act ? SYNC_POL : ~SYNC_POL;
    vsync_d = vs_act ? SYNC_POL : ~SYNC_POL;
    video_d = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
    // Entering (0,0) only happens when advancing from the last pixel of the frame.
    fs_d    = pix_en && (x_q == H_LAST) && (y_q == V_LAST);
  end

  // Position and decoded flags; reset parks at the last pixel so the first advance lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      fs_q    <= fs_d;
    end
  end

  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fs_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  // Frame counter bumps on the same edge that raises frame_start and wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 8'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing generator that sits directly upstream of the square-drawing/colour stage.
- Produces the pixel coordinates (pix_x, pix_y), hsync, vsync, video_on and a frame_start pulse from free-running horizontal and vertical counters.
- Downstream colour logic compares pix_x/pix_y against shape bounds and must gate its RGB output with video_on.
- Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate; the rate is derived from a faster clock via pix_en.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate enable; all state advances only on clk edges where pix_en=1
- pix_x  out  11  current horizontal count, 0..H_TOTAL-1
- pix_y  out  11  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  1 when pix_x<H_VISIBLE and pix_y<V_VISIBLE
- frame_start  out  1  single-clk pulse when the position becomes (0,0)
- frame_cnt  out  8  frames started; present only with VGA_FRAME_CNT_EN

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be <=2048; elaboration error otherwise.
- Reset (pre-frame state, applied immediately on rst_n low, including mid-frame):
  - pix_x=H_TOTAL-1, pix_y=V_TOTAL-1.
  - hsync and vsync at inactive level (!SYNC_POL).
  - video_on=0, frame_start=0.
- Advance (clk edge with pix_en=1):
  - if pix_x==H_TOTAL-1: pix_x<=0, and pix_y<=(pix_y==V_TOTAL-1)?0:pix_y+1
  - else: pix_x<=pix_x+1
- Output alignment: hsync, vsync and video_on are registered and decoded from the next position on the same edge. In every cycle they correspond exactly to the current pix_x/pix_y, with no skew and no combinational path from the counters.
- Sync windows:
  - hsync is active when H_VISIBLE+H_FP <= pix_x < H_VISIBLE+H_FP+H_SYNC (default 656..751).
  - vsync is active when V_VISIBLE+V_FP <= pix_y < V_VISIBLE+V_FP+V_SYNC (default 490..491).
  - vsync changes only at line boundaries (pix_x=0).
- frame_start:
  - Asserted for exactly one clk on the edge where the position enters (0,0).
  - Cleared on the next clk edge regardless of pix_en.
  - The first pix_en after reset release produces (0,0) and a frame_start pulse.
- pix_en=0: all outputs hold, except frame_start, which drops to 0.
- During blanking, pix_x/pix_y keep counting beyond the visible range; they are not clamped.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds the 8-bit frame_cnt output port.
  - Reset value 0.
  - Increments on the same edge that asserts frame_start (first frame after reset reads 1).
  - Wraps 255->0.
  - Async reset mid-frame returns it to 0.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Release rst_n with pix_en=1 constantly -> before release pix_x=799, pix_y=524, hsync=vsync=1, video_on=0; after the first edge pix_x=0, pix_y=0, video_on=1, frame_start=1 for one clk.
- Run one line -> video_on=1 for pix_x 0..639 and 0 for 640..799; hsync=0 exactly for pix_x 656..751 (96 pixels); pix_y increments when pix_x wraps 799->0.
- Run two full frames -> frame_start pulses exactly 420000 pix_en cycles apart; vsync=0 for pix_y 490..491 only; pix_y wraps 524->0.
- pix_en high every 2nd clk (50 MHz clock) -> outputs hold on pix_en=0 cycles; frame_start is 1 clk wide; line length is 1600 clks.
- Assert rst_n=0 asynchronously at (300,200) -> outputs go to pix_x=799, pix_y=524, hsync=vsync=1, video_on=0 without waiting for clk; after release, the counting sequence restarts at (0,0).
- With VGA_FRAME_CNT_EN: frame_cnt=0 in reset and 1 after the first frame_start; after 256 frames it wraps to 0; mid-frame reset clears it to 0.
